// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-based hazard, forwarding and drain-then-freeze halt controller for an N-stage pipeline.
// Optional performance counters are built when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int unsigned STAGES     = 3,
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned LOAD_READY = 1,
    parameter int unsigned SEL_W      = $clog2(STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_wr,
    input  logic                  issue_load,
    input  logic                  issue_halt,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  src1_used,
    input  logic                  src2_used,
    input  logic                  flush,
    output logic                  stall,
    output logic [SEL_W-1:0]      fwd1_sel,
    output logic [SEL_W-1:0]      fwd2_sel,
    output logic [STAGES-1:0]     stage_valid,
    output logic                  retire,
    output logic                  halted
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_retire_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_e;

    state_e                state_q, state_d;
    logic [SEL_W-1:0]      cnt_q, cnt_d;
    logic [STAGES-1:0]     valid_q, valid_d;
    logic [STAGES-1:0]     wr_q, wr_d;
    logic [STAGES-1:0]     load_q, load_d;
    logic [REG_ADDR_W-1:0] rd_q [STAGES];
    logic [REG_ADDR_W-1:0] rd_d [STAGES];
    logic                  halted_q, halted_d;
    logic                  haz1, haz2;
    logic                  issue_ok;

    // Walk oldest to youngest so the youngest matching entry is the last write.
    always_comb begin : match_logic
        int unsigned idx;
        idx      = 0;
        fwd1_sel = '0;
        fwd2_sel = '0;
        haz1     = 1'b0;
        haz2     = 1'b0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            idx = STAGES - 1 - k;
            if (src1_used && valid_q[idx] && wr_q[idx] && rd_q[idx] == src1) begin
                if (load_q[idx] && idx < LOAD_READY) begin
                    fwd1_sel = '0;
                    haz1     = 1'b1;
                end else begin
                    fwd1_sel = SEL_W'(idx + 1);
                    haz1     = 1'b0;
                end
            end
            if (src2_used && valid_q[idx] && wr_q[idx] && rd_q[idx] == src2) begin
                if (load_q[idx] && idx < LOAD_READY) begin
                    fwd2_sel = '0;
                    haz2     = 1'b1;
                end else begin
                    fwd2_sel = SEL_W'(idx + 1);
                    haz2     = 1'b0;
                end
            end
        end
    end

    always_comb begin
        stall    = (state_q != ST_RUN) || (issue_valid && (haz1 || haz2));
        issue_ok = issue_valid && !stall && !flush && (state_q == ST_RUN);
    end

    // HALT occupies a slot but never writes, so it can never retire.
    always_comb begin
        valid_d  = {valid_q[STAGES-2:0], issue_ok};
        wr_d     = {wr_q[STAGES-2:0], issue_ok && issue_wr && !issue_halt};
        load_d   = {load_q[STAGES-2:0], issue_ok && issue_load};
        rd_d[0]  = issue_rd;
        for (int unsigned k = 1; k < STAGES; k++) begin
            rd_d[k] = rd_q[k-1];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (issue_ok && issue_halt) begin
                    state_d = ST_DRAIN;
                    cnt_d   = SEL_W'(STAGES);
                end
            end
            ST_DRAIN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (cnt_d == '0 && valid_d == '0) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        halted_d = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            valid_q  <= '0;
            wr_q     <= '0;
            load_q   <= '0;
            halted_q <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                rd_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            wr_q     <= wr_d;
            load_q   <= load_d;
            halted_q <= halted_d;
            rd_q     <= rd_d;
        end
    end

    always_comb begin
        stage_valid = valid_q;
        retire      = valid_q[STAGES-1] && wr_q[STAGES-1];
        halted      = halted_q;
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        retire_cnt_d = retire_cnt_q;
        if (state_q == ST_RUN && stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (state_q != ST_HALTED && retire) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    always_comb begin
        perf_stall_cnt  = stall_cnt_q;
        perf_retire_cnt = retire_cnt_q;
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: instance A (STAGES=3, LOAD_READY=1), instance B (STAGES=5, LOAD_READY=3).
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A signals
    logic       a_rst, a_v, a_wr, a_ld, a_hl, a_fl, a_u1, a_u2;
    logic [3:0] a_rd, a_s1, a_s2;
    logic       a_stall, a_retire, a_halted;
    logic [1:0] a_fwd1, a_fwd2;
    logic [2:0] a_sv;

    // Instance B signals
    logic       b_rst, b_v, b_wr, b_ld, b_hl, b_fl, b_u1, b_u2;
    logic [3:0] b_rd, b_s1, b_s2;
    logic       b_stall, b_retire, b_halted;
    logic [2:0] b_fwd1, b_fwd2;
    logic [4:0] b_sv;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] a_pstall, a_pret, b_pstall, b_pret;
`endif

    pipe_hazard_ctrl #(.STAGES(3), .REG_ADDR_W(4), .LOAD_READY(1)) dut_a (
        .clk(clk), .rst(a_rst), .issue_valid(a_v), .issue_rd(a_rd), .issue_wr(a_wr),
        .issue_load(a_ld), .issue_halt(a_hl), .src1(a_s1), .src2(a_s2),
        .src1_used(a_u1), .src2_used(a_u2), .flush(a_fl), .stall(a_stall),
        .fwd1_sel(a_fwd1), .fwd2_sel(a_fwd2), .stage_valid(a_sv), .retire(a_retire),
        .halted(a_halted)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        , .perf_stall_cnt(a_pstall), .perf_retire_cnt(a_pret)
`endif
    );

    pipe_hazard_ctrl #(.STAGES(5), .REG_ADDR_W(4), .LOAD_READY(3)) dut_b (
        .clk(clk), .rst(b_rst), .issue_valid(b_v), .issue_rd(b_rd), .issue_wr(b_wr),
        .issue_load(b_ld), .issue_halt(b_hl), .src1(b_s1), .src2(b_s2),
        .src1_used(b_u1), .src2_used(b_u2), .flush(b_fl), .stall(b_stall),
        .fwd1_sel(b_fwd1), .fwd2_sel(b_fwd2), .stage_valid(b_sv), .retire(b_retire),
        .halted(b_halted)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        , .perf_stall_cnt(b_pstall), .perf_retire_cnt(b_pret)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic a_drv(input logic v, input logic [3:0] rd, input logic wr, input logic ld,
                         input logic hl, input logic fl, input logic [3:0] s1, input logic u1,
                         input logic [3:0] s2, input logic u2);
        a_v = v; a_rd = rd; a_wr = wr; a_ld = ld; a_hl = hl; a_fl = fl;
        a_s1 = s1; a_u1 = u1; a_s2 = s2; a_u2 = u2;
    endtask

    task automatic b_drv(input logic v, input logic [3:0] rd, input logic wr, input logic ld,
                         input logic hl, input logic fl, input logic [3:0] s1, input logic u1,
                         input logic [3:0] s2, input logic u2);
        b_v = v; b_rd = rd; b_wr = wr; b_ld = ld; b_hl = hl; b_fl = fl;
        b_s1 = s1; b_u1 = u1; b_s2 = s2; b_u2 = u2;
    endtask

    task automatic a_drain;
        a_drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (6) tick();
    endtask

    task automatic b_drain;
        b_drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (8) tick();
    endtask

    task automatic test_reset;
        a_rst = 1'b1; b_rst = 1'b1;
        a_drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        b_drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        a_rst = 1'b0; b_rst = 1'b0;
        #1;
        total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0d exp=0", a_stall); end
        total++; if (a_fwd1 !== 2'd0 || a_fwd2 !== 2'd0) begin bad++; $display("FAIL rst_fwd got=%0d/%0d exp=0/0", a_fwd1, a_fwd2); end
        total++; if (a_sv !== 3'b000) begin bad++; $display("FAIL rst_valid got=%b exp=000", a_sv); end
        total++; if (a_retire !== 1'b0 || a_halted !== 1'b0) begin bad++; $display("FAIL rst_ret_halt got=%0d/%0d exp=0/0", a_retire, a_halted); end
        total++; if (b_sv !== 5'b00000 || b_stall !== 1'b0) begin bad++; $display("FAIL rst_b got sv=%b stall=%0d exp=00000/0", b_sv, b_stall); end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        total++; if (b_pstall !== 32'd0 || b_pret !== 32'd0) begin bad++; $display("FAIL rst_perf got=%0d/%0d exp=0/0", b_pstall, b_pret); end
`endif
    endtask

    task automatic test_forward;
        a_drain();
        a_drv(1, 4'd2, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        total++; if (a_stall !== 1'b0 || a_fwd1 !== 2'd0) begin bad++; $display("FAIL fwd_first got stall=%0d sel=%0d exp=0/0", a_stall, a_fwd1); end
        tick();
        a_drv(1, 4'd3, 1, 0, 0, 0, 4'd2, 1, 0, 0);
        #1;
        total++; if (a_fwd1 !== 2'd1) begin bad++; $display("FAIL fwd_sel1 got=%0d exp=1", a_fwd1); end
        total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL fwd_stall got=%0d exp=0", a_stall); end
        total++; if (a_sv !== 3'b001) begin bad++; $display("FAIL fwd_sv1 got=%b exp=001", a_sv); end
        tick();
        a_drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        total++; if (a_sv !== 3'b011 || a_retire !== 1'b0) begin bad++; $display("FAIL fwd_sv2 got sv=%b ret=%0d exp=011/0", a_sv, a_retire); end
        tick(); #1;
        total++; if (a_sv !== 3'b110 || a_retire !== 1'b1) begin bad++; $display("FAIL fwd_sv3 got sv=%b ret=%0d exp=110/1", a_sv, a_retire); end
        tick(); tick(); #1;
        total++; if (a_sv !== 3'b000 || a_retire !== 1'b0) begin bad++; $display("FAIL fwd_sv5 got sv=%b ret=%0d exp=000/0", a_sv, a_retire); end
    endtask

    task automatic test_load_use;
        a_drain();
        a_drv(1, 4'd5, 1, 1, 0, 0, 0, 0, 0, 0);
        #1;
        total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL lu_load_stall got=%0d exp=0", a_stall); end
        tick();
        a_drv(1, 4'd6, 0, 0, 0, 0, 4'd5, 1, 0, 0);
        #1;
        total++; if (a_stall !== 1'b1 || a_fwd1 !== 2'd0) begin bad++; $display("FAIL lu_hazard got stall=%0d sel=%0d exp=1/0", a_stall, a_fwd1); end
        tick(); #1;
        total++; if (a_stall !== 1'b0 || a_fwd1 !== 2'd2) begin bad++; $display("FAIL lu_resolve got stall=%0d sel=%0d exp=0/2", a_stall, a_fwd1); end
        total++; if (a_sv !== 3'b010) begin bad++; $display("FAIL lu_bubble got=%b exp=010", a_sv); end
        tick();
        a_drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        total++; if (a_sv !== 3'b101 || a_retire !== 1'b1) begin bad++; $display("FAIL lu_after got sv=%b ret=%0d exp=101/1", a_sv, a_retire); end
    endtask

    task automatic test_youngest;
        a_drain();
        a_drv(1, 4'd4, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        a_drv(1, 4'd7, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        a_drv(1, 4'd4, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        a_drv(1, 4'd8, 1, 0, 0, 0, 4'd4, 1, 4'd4, 0);
        #1;
        total++; if (a_fwd1 !== 2'd1) begin bad++; $display("FAIL yng_sel1 got=%0d exp=1", a_fwd1); end
        total++; if (a_fwd2 !== 2'd0) begin bad++; $display("FAIL yng_unused got=%0d exp=0", a_fwd2); end
        total++; if (a_sv !== 3'b111 || a_stall !== 1'b0) begin bad++; $display("FAIL yng_state got sv=%b stall=%0d exp=111/0", a_sv, a_stall); end
        a_s2 = 4'd7; a_u2 = 1'b1;
        #1;
        total++; if (a_fwd1 !== 2'd1 || a_fwd2 !== 2'd2) begin bad++; $display("FAIL yng_both got=%0d/%0d exp=1/2", a_fwd1, a_fwd2); end
        tick();
    endtask

    task automatic test_flush_halt;
        a_drain();
        a_drv(1, 4'd0, 0, 0, 1, 1, 0, 0, 0, 0);
        #1;
        total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL fh_stall got=%0d exp=0", a_stall); end
        tick();
        a_drv(1, 4'd1, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        total++; if (a_sv !== 3'b000) begin bad++; $display("FAIL fh_killed got=%b exp=000", a_sv); end
        total++; if (a_stall !== 1'b0 || a_halted !== 1'b0) begin bad++; $display("FAIL fh_run got stall=%0d halted=%0d exp=0/0", a_stall, a_halted); end
        tick();
        a_drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        total++; if (a_sv !== 3'b001) begin bad++; $display("FAIL fh_issue got=%b exp=001", a_sv); end
    endtask

    task automatic test_halt;
        a_drain();
        a_drv(1, 4'd9, 1, 0, 1, 0, 0, 0, 0, 0);
        #1;
        total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL hlt_c0 got stall=%0d exp=0", a_stall); end
        tick();
        a_drv(1, 4'd1, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        total++; if (a_stall !== 1'b1 || a_sv !== 3'b001 || a_halted !== 1'b0) begin bad++; $display("FAIL hlt_c1 got stall=%0d sv=%b halted=%0d exp=1/001/0", a_stall, a_sv, a_halted); end
        tick(); #1;
        total++; if (a_stall !== 1'b1 || a_sv !== 3'b010) begin bad++; $display("FAIL hlt_c2 got stall=%0d sv=%b exp=1/010", a_stall, a_sv); end
        tick(); #1;
        total++; if (a_sv !== 3'b100 || a_retire !== 1'b0 || a_halted !== 1'b0) begin bad++; $display("FAIL hlt_c3 got sv=%b ret=%0d halted=%0d exp=100/0/0", a_sv, a_retire, a_halted); end
        tick(); #1;
        total++; if (a_halted !== 1'b1 || a_sv !== 3'b000 || a_stall !== 1'b1) begin bad++; $display("FAIL hlt_c4 got halted=%0d sv=%b stall=%0d exp=1/000/1", a_halted, a_sv, a_stall); end
        repeat (3) tick();
        #1;
        total++; if (a_halted !== 1'b1 || a_sv !== 3'b000) begin bad++; $display("FAIL hlt_frozen got halted=%0d sv=%b exp=1/000", a_halted, a_sv); end
        a_rst = 1'b1;
        a_drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        a_rst = 1'b0;
        #1;
        total++; if (a_halted !== 1'b0 || a_stall !== 1'b0) begin bad++; $display("FAIL hlt_release got halted=%0d stall=%0d exp=0/0", a_halted, a_stall); end
        // reset in the middle of a drain
        tick();
        a_drv(1, 4'd0, 0, 0, 1, 0, 0, 0, 0, 0);
        tick();
        a_rst = 1'b1;
        a_drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        a_rst = 1'b0;
        a_drv(1, 4'd1, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        total++; if (a_stall !== 1'b0 || a_sv !== 3'b000) begin bad++; $display("FAIL drain_rst got stall=%0d sv=%b exp=0/000", a_stall, a_sv); end
        tick();
        a_drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        total++; if (a_sv !== 3'b001) begin bad++; $display("FAIL drain_rst_issue got=%b exp=001", a_sv); end
    endtask

    task automatic test_b_load_use;
        int n;
        b_drain();
        b_drv(1, 4'd5, 1, 1, 0, 0, 0, 0, 0, 0);
        #1;
        total++; if (b_stall !== 1'b0) begin bad++; $display("FAIL blu_load got stall=%0d exp=0", b_stall); end
        tick();
        b_drv(1, 4'd6, 0, 0, 0, 0, 4'd5, 1, 0, 0);
        #1;
        n = 0;
        while (b_stall === 1'b1 && n < 10) begin
            n++;
            tick(); #1;
        end
        total++; if (n !== 3) begin bad++; $display("FAIL blu_cycles got=%0d exp=3", n); end
        total++; if (b_fwd1 !== 3'd4) begin bad++; $display("FAIL blu_sel got=%0d exp=4", b_fwd1); end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        total++; if (b_pstall !== 32'd3) begin bad++; $display("FAIL blu_perf got=%0d exp=3", b_pstall); end
`endif
        tick();
        b_drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_b_retire;
        int cnt;
        logic [3:0] r;
        b_rst = 1'b1;
        b_drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        b_rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            r = 4'(i + 1);
            b_drv(1, r, 1, 0, 0, 0, 0, 0, 0, 0);
            #1;
            if (b_retire === 1'b1) cnt++;
            tick();
        end
        b_drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            #1;
            if (b_retire === 1'b1) cnt++;
            tick();
        end
        total++; if (cnt !== 10) begin bad++; $display("FAIL bret_pulses got=%0d exp=10", cnt); end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        total++; if (b_pret !== 32'd10) begin bad++; $display("FAIL bret_perf got=%0d exp=10", b_pret); end
        total++; if (b_pstall !== 32'd0) begin bad++; $display("FAIL bret_nostall got=%0d exp=0", b_pstall); end
`endif
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_youngest();
        test_flush_halt();
        test_halt();
        test_b_load_use();
        test_b_retire();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard, forwarding and halt controller for the N-stage integer pipeline; the next generation of the fixed three-stage haz1/haz2/stall/halt_sys logic.
- Tracks every in-flight instruction after decode in a per-stage scoreboard.
- Issues per-operand forwarding selects and load-use stalls, and sequences halt as drain-then-freeze.
- Sits beside the decode stage; its outputs drive the operand muxes and the pipeline-register enables of all later stages.

Parameters:
- STAGES, 3: post-decode stages tracked (entry 0 = execute, entry STAGES-1 = writeback); legal range 2..8.
- REG_ADDR_W, 4: register address width.
- LOAD_READY, 1: lowest entry index at which a load result can be forwarded; legal range 1..STAGES-1.
- SEL_W, $clog2(STAGES+1): width of forwarding selects.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  decode presents an instruction this cycle
- issue_rd  in  REG_ADDR_W  destination register
- issue_wr  in  1  instruction writes issue_rd
- issue_load  in  1  instruction is a memory load
- issue_halt  in  1  instruction is HALT
- src1 / src2  in  REG_ADDR_W  source register addresses
- src1_used / src2_used  in  1  source operand is actually read
- flush  in  1  branch redirect; kills the decode instruction
- stall  out  1  hold fetch/decode and insert a bubble into entry 0
- fwd1_sel / fwd2_sel  out  SEL_W  0 = register file; k = forward from entry k-1
- stage_valid  out  STAGES  per-entry valid bits
- retire  out  1  entry STAGES-1 is valid with wr set this cycle
- halted  out  1  pipeline drained and frozen
- perf_stall_cnt / perf_retire_cnt  out  32  present only with PIPE_HAZARD_CTRL_PERF_EN

Behaviour:
Reset:
- All entries invalid; state RUN.
- stall=0, fwd selects=0, halted=0, retire=0, counters=0.
- Reset mid-drain or while HALTED returns to RUN the following cycle.

Scoreboard:
- Each entry holds {valid, rd, wr, load}.
- Every cycle, entry k moves to entry k+1; entry STAGES-1 drops out.
- Entry 0 loads the decode instruction when issue_valid & !stall & !flush & state==RUN; otherwise entry 0 loads a bubble (valid=0).

Match and forwarding (combinational, same cycle as issue):
- An entry matches srcN when srcN_used & valid & wr & rd==srcN.
- The youngest (lowest index) matching entry wins.
- Winner not a load, or winner index >= LOAD_READY: fwdN_sel = index+1.
- Winner is a load with index < LOAD_READY: load-use hazard, so stall=1 and fwdN_sel=0.
- No match: fwdN_sel=0.
- stall = hazard1 | hazard2, gated by issue_valid & state==RUN.
- Stall lasts until the load reaches LOAD_READY, i.e. LOAD_READY-index cycles.
- Both operands matching different entries are resolved independently.

State machine:
- RUN: issue_halt & issue_valid & !stall & !flush goes to DRAIN. The HALT itself enters entry 0 as valid with wr=0.
- DRAIN: no issue; stall=1. A counter loads STAGES and decrements each cycle; at 0 with all entries invalid, go to HALTED.
- HALTED: halted=1, stall=1, all entries invalid; leave only on rst.
- flush in the same cycle as issue_halt: flush wins and the state stays RUN.
- flush while stalled: the bubble is still inserted and the stall condition is re-evaluated next cycle.

retire:
- retire = stage_valid[STAGES-1] & wr of entry STAGES-1.
- Registered scoreboard output; no extra latency.

Optional Feature:
PIPE_HAZARD_CTRL_PERF_EN
- Defined:
  - perf_stall_cnt increments every cycle stall=1 in RUN.
  - perf_retire_cnt increments on every retire.
  - Both are 32-bit, wrap at 2^32, clear on rst, and freeze in HALTED.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- STAGES=3, LOAD_READY=1: ADD r2 then ADD r3,r2 on consecutive cycles -> second issue sees fwd1_sel=1, stall=0.
- Load r5 then use r5 next cycle -> stall=1 for exactly 1 cycle; bubble in entry 0; the following cycle shows fwd1_sel=2.
- r4 written by entries 0 and 2, src1=r4 -> fwd1_sel=1 (youngest wins); src2 unused -> fwd2_sel=0.
- HALT issued at cycle 10 -> stall=1 from cycle 11; halted=1 at cycle 10+STAGES+1; no further entries valid; rst releases to RUN.
- flush asserted with issue_halt -> no DRAIN; entry 0 invalid next cycle; state stays RUN.
- STAGES=5, LOAD_READY=3, perf enabled: load then use -> 3 stall cycles, perf_stall_cnt=3; 10 writing instructions retired -> perf_retire_cnt=10.
